// File: rtl/mem_io_sys.sv
// Memory and I/O subsystem on the CPU's external bus: word RAM, output port,
// synchronised input port, 16-bit compare timer and a clear-on-read status word.
module mem_io_sys #(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Abus,
    input  logic [15:0] Dbusout,
    input  logic        memrd,
    input  logic        memwr,
    output logic [15:0] Dbusin,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic        timer_irq,
    output logic        bus_err
);

    localparam logic [15:0] A_OUT    = 16'hFFF0;
    localparam logic [15:0] A_IN     = 16'hFFF1;
    localparam logic [15:0] A_TCTRL  = 16'hFFF2;
    localparam logic [15:0] A_TCOUNT = 16'hFFF3;
    localparam logic [15:0] A_TCMP   = 16'hFFF4;
    localparam logic [15:0] A_STATUS = 16'hFFF5;

    logic [15:0] mem [0:(1<<AW)-1];

    logic [15:0] out_q,    out_d;
    logic [15:0] sync1_q,  sync1_d;
    logic [15:0] sync2_q,  sync2_d;
    logic [2:0]  tctrl_q,  tctrl_d;
    logic [15:0] tcount_q, tcount_d;
    logic [15:0] tcmp_q,   tcmp_d;
    logic [1:0]  status_q, status_d;

    logic rd_ok, wr_ok, rw_clash, ram_sel, ram_we, match;

    assign rd_ok    = memrd & ~memwr;
    assign wr_ok    = memwr & ~memrd;
    assign rw_clash = memrd & memwr;
    assign ram_sel  = (Abus[15:AW] == '0);
    assign ram_we   = wr_ok & ram_sel;

    // Match uses the pre-write count so a CPU write to TCOUNT cannot hide it.
    assign match    = tctrl_q[0] && (tcount_q == tcmp_q);

    always_comb begin
        Dbusin = 16'h0000;
        if (rd_ok) begin
            if (ram_sel) begin
                Dbusin = mem[Abus[AW-1:0]];
            end else begin
                case (Abus)
                    A_OUT:    Dbusin = out_q;
                    A_IN:     Dbusin = sync2_q;
                    A_TCTRL:  Dbusin = {13'h0000, tctrl_q};
                    A_TCOUNT: Dbusin = tcount_q;
                    A_TCMP:   Dbusin = tcmp_q;
                    A_STATUS: Dbusin = {14'h0000, status_q};
                    default:  Dbusin = 16'h0000;
                endcase
            end
        end
    end

    always_comb begin
        out_d    = out_q;
        sync1_d  = io_in;
        sync2_d  = sync1_q;
        tctrl_d  = tctrl_q;
        tcmp_d   = tcmp_q;
        tcount_d = tcount_q;
        status_d = status_q;

        if (tctrl_q[0]) begin
            tcount_d = (match && tctrl_q[1]) ? 16'h0000 : tcount_q + 16'd1;
        end

        if (wr_ok) begin
            case (Abus)
                A_OUT:    out_d    = Dbusout;
                A_TCTRL:  tctrl_d  = Dbusout[2:0];
                A_TCOUNT: tcount_d = Dbusout;
                A_TCMP:   tcmp_d   = Dbusout;
                default:  ;
            endcase
        end

        // Clear first so a same-edge set event wins.
        if (rd_ok && Abus == A_STATUS) begin
            status_d = 2'b00;
        end
        if (match) begin
            status_d[0] = 1'b1;
        end
        if (rw_clash) begin
            status_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= 16'h0000;
            sync1_q  <= 16'h0000;
            sync2_q  <= 16'h0000;
            tctrl_q  <= 3'b000;
            tcount_q <= 16'h0000;
            tcmp_q   <= 16'hFFFF;
            status_q <= 2'b00;
        end else begin
            out_q    <= out_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            tctrl_q  <= tctrl_d;
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            status_q <= status_d;
        end
    end

    // RAM has no reset; reset only blocks a concurrent write.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            mem[Abus[AW-1:0]] <= Dbusout;
        end
    end

    assign io_out    = out_q;
    assign bus_err   = status_q[1];
    assign timer_irq = status_q[0] & tctrl_q[2];

endmodule

// File: tb/tb_mem_io_sys.sv
// Scoreboard bench for mem_io_sys: each bus cycle queues the expected Dbusin
// value, which is popped and compared mid-cycle.
module tb_mem_io_sys;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Abus, Dbusout, Dbusin, io_in, io_out;
    logic        memrd, memwr, timer_irq, bus_err;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    localparam logic [15:0] A_OUT    = 16'hFFF0;
    localparam logic [15:0] A_IN     = 16'hFFF1;
    localparam logic [15:0] A_TCTRL  = 16'hFFF2;
    localparam logic [15:0] A_TCOUNT = 16'hFFF3;
    localparam logic [15:0] A_TCMP   = 16'hFFF4;
    localparam logic [15:0] A_STATUS = 16'hFFF5;

    mem_io_sys #(.AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .Abus      (Abus),
        .Dbusout   (Dbusout),
        .memrd     (memrd),
        .memwr     (memwr),
        .Dbusin    (Dbusin),
        .io_in     (io_in),
        .io_out    (io_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, queue expected Dbusin, compare mid-cycle, take the edge.
    task automatic cyc(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp, input string tag);
        Abus = a; Dbusout = d; memrd = r; memwr = w;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        chk(tag_q.pop_front(), Dbusin, exp_q.pop_front());
        @(posedge clk);
        #1;
        memrd = 1'b0; memwr = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b0, 1'b1, a, d, 16'h0000, "wr_dbus0");
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        cyc(1'b1, 1'b0, a, 16'h0000, exp, tag);
    endtask

    initial begin
        reset = 1'b1; memrd = 1'b0; memwr = 1'b1;
        Abus = A_OUT; Dbusout = 16'h1234; io_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_io_out", io_out, 16'h0000);
        chk("rst_irq", {15'h0, timer_irq}, 16'h0000);
        chk("rst_bus_err", {15'h0, bus_err}, 16'h0000);
        chk("rst_dbusin", Dbusin, 16'h0000);
        reset = 1'b0; memwr = 1'b0;

        rd(A_TCMP,   16'hFFFF, "rst_tcmp");
        rd(A_OUT,    16'h0000, "rst_out");
        rd(A_TCTRL,  16'h0000, "rst_tctrl");
        rd(A_TCOUNT, 16'h0000, "rst_tcount");
        rd(A_STATUS, 16'h0000, "rst_status");
        rd(A_IN,     16'h0000, "rst_in");

        // RAM and address-map edge
        wr(16'h0000, 16'hA5A5);
        wr(16'h03FF, 16'h5A5A);
        rd(16'h0000, 16'hA5A5, "ram_lo");
        rd(16'h03FF, 16'h5A5A, "ram_hi");
        rd(16'h0400, 16'h0000, "unmapped_400");
        wr(16'h0400, 16'hBEEF);
        rd(16'h0000, 16'hA5A5, "ram_lo_after_400");
        rd(16'hFFF6, 16'h0000, "unmapped_fff6");
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, "idle_dbus0");

        // Output and synchronised input
        wr(A_OUT, 16'h00FF);
        chk("io_out", io_out, 16'h00FF);
        rd(A_OUT, 16'h00FF, "out_rd");
        io_in = 16'hC3C3;
        rd(A_IN, 16'h0000, "in_cyc1");
        rd(A_IN, 16'h0000, "in_cyc2");
        rd(A_IN, 16'hC3C3, "in_cyc3");
        wr(A_IN, 16'h0000);
        rd(A_IN, 16'hC3C3, "in_ro");

        // Timer with auto-reload
        wr(A_TCMP, 16'h0003);
        wr(A_TCOUNT, 16'h0000);
        wr(A_TCTRL, 16'h0007);
        rd(A_TCOUNT, 16'h0000, "tc0");
        rd(A_TCOUNT, 16'h0001, "tc1");
        rd(A_TCOUNT, 16'h0002, "tc2");
        chk("irq_pre", {15'h0, timer_irq}, 16'h0000);
        rd(A_TCOUNT, 16'h0003, "tc3");
        chk("irq_set", {15'h0, timer_irq}, 16'h0001);
        rd(A_TCOUNT, 16'h0000, "tc_reload");
        rd(A_STATUS, 16'h0001, "status_match");
        chk("irq_clr", {15'h0, timer_irq}, 16'h0000);
        rd(A_TCOUNT, 16'h0002, "tc2b");

        // STATUS read on the match edge: set wins
        rd(A_STATUS, 16'h0000, "race_rd_old");
        chk("race_irq", {15'h0, timer_irq}, 16'h0001);
        rd(A_STATUS, 16'h0001, "race_sticky");
        chk("race_irq_clr", {15'h0, timer_irq}, 16'h0000);
        rd(A_TCOUNT, 16'h0001, "tc1c");
        rd(A_TCOUNT, 16'h0002, "tc2c");
        wr(A_TCOUNT, 16'h0010);
        chk("wr_match_irq", {15'h0, timer_irq}, 16'h0001);
        rd(A_TCOUNT, 16'h0010, "wr_override");
        rd(A_STATUS, 16'h0001, "wr_match_status");

        // Timer without reload, then 16-bit wrap
        wr(A_TCTRL, 16'h0005);
        rd(A_TCTRL, 16'h0005, "tctrl_5");
        wr(A_TCOUNT, 16'h0002);
        rd(A_TCOUNT, 16'h0002, "nr2");
        rd(A_TCOUNT, 16'h0003, "nr3");
        chk("nr_irq", {15'h0, timer_irq}, 16'h0001);
        rd(A_TCOUNT, 16'h0004, "nr4");
        rd(A_STATUS, 16'h0001, "nr_status");
        wr(A_TCOUNT, 16'hFFFE);
        rd(A_TCOUNT, 16'hFFFE, "wrap_fffe");
        rd(A_TCOUNT, 16'hFFFF, "wrap_ffff");
        rd(A_TCOUNT, 16'h0000, "wrap_0000");
        wr(A_TCTRL, 16'hFFF8);
        rd(A_TCTRL, 16'h0000, "tctrl_mask");
        rd(A_TCOUNT, 16'h0002, "hold_a");
        rd(A_TCOUNT, 16'h0002, "hold_b");

        // Bus error
        chk("be_pre", {15'h0, bus_err}, 16'h0000);
        cyc(1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, "be_dbus0");
        chk("be_set", {15'h0, bus_err}, 16'h0001);
        rd(16'h0000, 16'hA5A5, "be_ram_kept");
        rd(A_STATUS, 16'h0002, "be_status");
        chk("be_clr", {15'h0, bus_err}, 16'h0000);
        rd(A_STATUS, 16'h0000, "status_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_sys.md
# mem_io_sys

Memory and I/O subsystem on the multicycle CPU's external bus. It serves the CPU's address bus, write data, `memrd` and `memwr`, and returns read data on the CPU's `Dbusin`. It contains a word-addressed RAM, a memory-mapped output port, a synchronised input port, a 16-bit timer with compare and interrupt, and a sticky status register. All reads complete in the same cycle they are asked for, because the CPU has no wait-state input.

## Interface
- `AW`, default 10: RAM address width. RAM holds 2^AW 16-bit words. Legal range 1..15.
- `clk`  in  1: system clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `Abus`  in  16: word address from the CPU.
- `Dbusout`  in  16: write data from the CPU.
- `memrd`  in  1: read strobe from the CPU.
- `memwr`  in  1: write strobe from the CPU.
- `Dbusin`  out  16: read data to the CPU. Combinational.
- `io_in`  in  16: asynchronous external input pins.
- `io_out`  out  16: output port register.
- `timer_irq`  out  1: timer interrupt, level.
- `bus_err`  out  1: sticky bus-error flag.

## Operation
- **Address map**
  - RAM: `Abus < 2^AW`.
  - 0xFFF0 OUT: read/write.
  - 0xFFF1 IN: read-only. Holds the 2-flop synchronised `io_in`.
  - 0xFFF2 TCTRL: read/write, bits [2:0]. Bit 0 = enable, bit 1 = auto-reload, bit 2 = irq enable. Upper bits read 0.
  - 0xFFF3 TCOUNT: read/write.
  - 0xFFF4 TCMP: read/write.
  - 0xFFF5 STATUS: read-only, clear-on-read. Bit 0 = match, bit 1 = bus error.
  - All other addresses, including 0xFFF6–0xFFF7, are unmapped: reads return 0x0000 and writes are ignored.
- **Read**
  - `Dbusin` = selected word while `memrd=1 && memwr=0`. Otherwise 0x0000.
  - RAM read is asynchronous from the array.
- **Write**
  - Occurs at the rising edge when `memwr=1 && memrd=0`.
  - Writes to read-only registers are ignored.
- **Bus error**
  - `memrd=1 && memwr=1` in the same cycle: no read, no write, `Dbusin` = 0.
  - STATUS bit 1 is set at the edge.
  - `bus_err` = STATUS bit 1.
- **Timer**, evaluated each edge when TCTRL.enable = 1
  - Match condition: the current TCOUNT equals TCMP.
  - On a match, STATUS bit 0 is set. TCOUNT then goes to 0 if auto-reload is set; otherwise it increments.
  - With no match, TCOUNT increments modulo 2^16 (0xFFFF wraps to 0x0000).
  - When disabled, TCOUNT holds and no match is evaluated.
  - `timer_irq` = STATUS bit 0 AND TCTRL.irqen.
- **Priorities**
  - A CPU write to TCOUNT overrides increment and reload in the same cycle.
  - The match check in that cycle uses the pre-write TCOUNT.
- **STATUS clear**
  - A valid read of 0xFFF5 clears both bits at that edge.
  - If a set event (match or bus error) occurs in the same cycle, the set wins for that bit.
- **Reset values**
  - OUT, `io_out` = 0x0000; TCTRL = 0; TCOUNT = 0x0000; TCMP = 0xFFFF.
  - STATUS = 0; both IN synchroniser stages = 0x0000.
  - `timer_irq` = 0, `bus_err` = 0.
  - `Dbusin` follows the read rule: 0 unless a valid read is active.
  - RAM contents are not reset and are undefined after power-up. Reset does not alter RAM.
- Reset has priority over any same-cycle bus access.

## Timing
- **Read latency:** 0 cycles. `Dbusin` is valid in the same cycle `memrd` and `Abus` are stable, and the CPU samples it at the end of that cycle.
- **Write latency:** 1 edge. Data is readable in the cycle after the write edge.
- **IN latency:** a change on `io_in` is visible at 0xFFF1 after 2 edges.
- **Timer:** a match is visible in STATUS and on `timer_irq` one edge after TCOUNT == TCMP is first present with enable = 1.
- **Clear-on-read:** the cleared value is visible from the cycle after the read. The read itself returns the pre-clear value.
- **Outputs:** `io_out`, `timer_irq` and `bus_err` are register-driven with no combinational path from the bus. `Dbusin` is the only combinational output.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `memwr=1` to 0xFFF0 and data 0x1234.
  - `io_out`, `timer_irq` and `bus_err` read 0.
  - TCMP reads 0xFFFF and OUT reads 0x0000, confirming the reset won over the write.
- **RAM:** write 0xA5A5 to 0x0000 and 0x5A5A to 0x03FF.
  - Reads return the same values.
  - Reading 0x0400 (unmapped, AW=10) returns 0x0000.
  - Writing 0xBEEF to 0x0400 leaves RAM 0x0000 unchanged.
- **I/O:** write 0x00FF to 0xFFF0.
  - `io_out` = 0x00FF after the edge.
  - Set `io_in` = 0xC3C3; 0xFFF1 reads 0xC3C3 on the 3rd cycle and not earlier.
- **Timer:** TCMP = 3, TCTRL = 0b111.
  - TCOUNT sequence 0,1,2,3,0,1…
  - STATUS bit 0 and `timer_irq` rise one edge after count 3.
  - Read STATUS → returns 0x0001 and `timer_irq` drops the next cycle.
  - Repeat with TCTRL = 0b101: the count passes 3→4, and 0xFFFF wraps to 0x0000.
- **Clear/set race:** time the STATUS read to coincide with a match edge.
  - The read returns the old value and STATUS bit 0 stays 1 afterwards.
  - Separately, write TCOUNT = 0x0010 in a match cycle: TCOUNT becomes 0x0010 and the match is still recorded.
- **Bus error:** `memrd=memwr=1` at 0x0000 with `Dbusout` = 0xFFFF.
  - `Dbusin` = 0 and RAM is unchanged.
  - `bus_err` = 1 from the next cycle.
  - Read STATUS → returns 0x0002, then `bus_err` = 0.
